// File: rtl/led_blink_multi_pkg.sv
// Shared definitions for the multi-channel LED driver.
// Contents: per-channel mode encodings and the burst FSM state encodings.
// Used by led_blink_multi (top) and led_blink_multi_channel.
package led_blink_multi_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_BURST = 2'b11
    } led_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ON_PH  = 2'b01,
        ST_OFF_PH = 2'b10,
        ST_GAP    = 2'b11
    } burst_state_e;

endpackage

// File: rtl/led_blink_multi_channel.sv
// One LED channel: shadow mode/half-period registers, phase counter,
// burst FSM and the registered raw LED output.
// Ports:
//   Clk50M    in  system clock
//   Rst_n     in  active-low reset (async assert, already release-synchronised)
//   cfg_load  in  capture mode_in/hp_in and restart the channel
//   tick      in  1 ms tick from the shared prescaler
//   mode_in   in  [1:0] requested mode
//   hp_in     in  [HP_W-1:0] requested half-period in ticks (0 treated as 1)
//   raw_led   out registered LED state before optional dimming
module led_blink_multi_channel
    import led_blink_multi_pkg::*;
#(
    parameter int HP_W    = 16,
    parameter int BURST_N = 3,
    parameter int GAP_HP  = 4
) (
    input  logic            Clk50M,
    input  logic            Rst_n,
    input  logic            cfg_load,
    input  logic            tick,
    input  logic [1:0]      mode_in,
    input  logic [HP_W-1:0] hp_in,
    output logic            raw_led
);

    // One counter serves both the hp phases and the longer GAP phase.
    localparam int GAP_W = HP_W + $clog2(GAP_HP);
    localparam int PC_W  = $clog2(BURST_N + 1);

    led_mode_e       mode_q, mode_d;
    burst_state_e    state_q, state_d;
    logic [HP_W-1:0] hp_q, hp_d;
    logic [GAP_W-1:0] cnt_q, cnt_d;
    logic [PC_W-1:0] pulse_q, pulse_d;
    logic            led_q, led_d;

    logic [GAP_W-1:0] hp_ext;
    logic [GAP_W-1:0] phase_term;
    logic [GAP_W-1:0] gap_term;
    logic             phase_done;
    logic             gap_done;

    assign hp_ext     = GAP_W'(hp_q);
    assign phase_term = hp_ext - GAP_W'(1);
    assign gap_term   = GAP_W'(GAP_HP) * hp_ext - GAP_W'(1);
    assign phase_done = (cnt_q == phase_term);
    assign gap_done   = (cnt_q == gap_term);

    always_comb begin
        mode_d  = mode_q;
        state_d = state_q;
        hp_d    = hp_q;
        cnt_d   = cnt_q;
        pulse_d = pulse_q;
        led_d   = led_q;
        if (cfg_load) begin
            // A load always wins over a coincident tick.
            mode_d  = led_mode_e'(mode_in);
            hp_d    = (hp_in == '0) ? HP_W'(1) : hp_in;
            cnt_d   = '0;
            pulse_d = '0;
            state_d = (mode_in == MODE_BURST) ? ST_ON_PH : ST_IDLE;
            led_d   = (mode_in != MODE_OFF);
        end else if (tick) begin
            unique case (mode_q)
                MODE_BLINK: begin
                    if (phase_done) begin
                        cnt_d = '0;
                        led_d = ~led_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                MODE_BURST: begin
                    unique case (state_q)
                        ST_ON_PH: begin
                            if (phase_done) begin
                                cnt_d   = '0;
                                state_d = ST_OFF_PH;
                                led_d   = 1'b0;
                                pulse_d = pulse_q + 1'b1;
                            end else begin
                                cnt_d = cnt_q + 1'b1;
                            end
                        end
                        ST_OFF_PH: begin
                            if (phase_done) begin
                                cnt_d = '0;
                                if (pulse_q == PC_W'(BURST_N)) begin
                                    state_d = ST_GAP;
                                    pulse_d = '0;
                                end else begin
                                    state_d = ST_ON_PH;
                                    led_d   = 1'b1;
                                end
                            end else begin
                                cnt_d = cnt_q + 1'b1;
                            end
                        end
                        ST_GAP: begin
                            if (gap_done) begin
                                cnt_d   = '0;
                                state_d = ST_ON_PH;
                                led_d   = 1'b1;
                            end else begin
                                cnt_d = cnt_q + 1'b1;
                            end
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk50M or negedge Rst_n) begin
        if (!Rst_n) begin
            mode_q  <= MODE_OFF;
            state_q <= ST_IDLE;
            hp_q    <= HP_W'(1);
            cnt_q   <= '0;
            pulse_q <= '0;
            led_q   <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            state_q <= state_d;
            hp_q    <= hp_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            led_q   <= led_d;
        end
    end

    assign raw_led = led_q;

endmodule

// File: rtl/led_blink_multi.sv
// Multi-channel LED driver: shared 1 ms prescaler feeding CHANNELS independent
// channels (OFF / ON / BLINK / BURST), all reconfigured together by cfg_load.
// Optional feature macro: LED_DIM_EN adds a global 8-bit PWM brightness gate.
// Ports:
//   Clk50M    in  system clock
//   Rst_n     in  asynchronous active-low reset (release synchronised inside)
//   cfg_load  in  1-cycle strobe capturing mode/half_per for every channel
//   mode      in  [2*CHANNELS-1:0] ch i = mode[2i+1:2i]
//   half_per  in  [HP_W*CHANNELS-1:0] ch i = half_per[HP_W*i +: HP_W]
//   dim_duty  in  [7:0] brightness /256, only used with LED_DIM_EN
//   tick      out 1-cycle pulse at the prescaler terminal count
//   led       out [CHANNELS-1:0] LED drive, 1 = lit
module led_blink_multi
    import led_blink_multi_pkg::*;
#(
    parameter int CLK_HZ   = 50_000_000,
    parameter int TICK_HZ  = 1_000,
    parameter int CHANNELS = 4,
    parameter int HP_W     = 16,
    parameter int BURST_N  = 3,
    parameter int GAP_HP   = 4
) (
    input  logic                     Clk50M,
    input  logic                     Rst_n,
    input  logic                     cfg_load,
    input  logic [2*CHANNELS-1:0]    mode,
    input  logic [HP_W*CHANNELS-1:0] half_per,
    input  logic [7:0]               dim_duty,
    output logic                     tick,
    output logic [CHANNELS-1:0]      led
);

    localparam int DIV  = CLK_HZ / TICK_HZ;
    localparam int PS_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PS_W-1:0] TERM = PS_W'(DIV - 1);

    // Reset: asserts immediately, releases on a clock edge after two flops.
    logic rst_meta_q, rst_meta_d;
    logic rst_sync_q, rst_sync_d;

    always_comb begin
        rst_meta_d = 1'b1;
        rst_sync_d = rst_meta_q;
    end

    always_ff @(posedge Clk50M or negedge Rst_n) begin
        if (!Rst_n) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= rst_meta_d;
            rst_sync_q <= rst_sync_d;
        end
    end

    // Shared prescaler.
    logic [PS_W-1:0] presc_q, presc_d;
    logic            tick_int;

    assign tick_int = (presc_q == TERM);

    always_comb begin
        presc_d = tick_int ? '0 : presc_q + 1'b1;
    end

    always_ff @(posedge Clk50M or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    assign tick = tick_int;

    // Channels.
    logic [CHANNELS-1:0] raw_led;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            led_blink_multi_channel #(
                .HP_W    (HP_W),
                .BURST_N (BURST_N),
                .GAP_HP  (GAP_HP)
            ) u_ch (
                .Clk50M   (Clk50M),
                .Rst_n    (rst_sync_q),
                .cfg_load (cfg_load),
                .tick     (tick_int),
                .mode_in  (mode[2*gi +: 2]),
                .hp_in    (half_per[HP_W*gi +: HP_W]),
                .raw_led  (raw_led[gi])
            );
        end
    endgenerate

`ifdef LED_DIM_EN
    // Free-running PWM; duty 0 is always dark, 255 is lit 255 of 256 clocks.
    logic [7:0] pwm_q, pwm_d;

    always_comb begin
        pwm_d = pwm_q + 8'd1;
    end

    always_ff @(posedge Clk50M or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            pwm_q <= '0;
        end else begin
            pwm_q <= pwm_d;
        end
    end

    assign led = raw_led & {CHANNELS{(pwm_q < dim_duty)}};
`else
    // dim_duty stays on the pinout but drives nothing in this build.
    logic dim_duty_unused;
    assign dim_duty_unused = ^dim_duty;
    assign led = raw_led;
`endif

endmodule
